// File: rtl/digit_entry_buffer_pkg.sv
// Shared sizing helpers for the digit entry buffer: slot width, blank code, counter width.
package digit_entry_pkg;

  function automatic int slot_w(input int data_w);
    return data_w + 1;
  endfunction

  // All-ones code of the requested width; callers truncate to their slot width.
  function automatic logic [63:0] blank(input int slot_w_v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < slot_w_v) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic int cnt_w(input int num_digits);
    return (num_digits <= 1) ? 1 : $clog2(num_digits);
  endfunction

endpackage

// File: rtl/digit_entry_buffer_if.sv
// Board-side entry controls plus the staged/committed slot views seen by the display path.
interface digit_entry_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 4
);
  localparam int SLOT_W = digit_entry_pkg::slot_w(DATA_W);
  localparam int CNT_W  = digit_entry_pkg::cnt_w(NUM_DIGITS);

  logic                         enter;
  logic                         del;
  logic                         clr;
  logic [DATA_W-1:0]            sw;
  logic [NUM_DIGITS*SLOT_W-1:0] disp;
  logic [NUM_DIGITS*SLOT_W-1:0] stage;
  logic [CNT_W-1:0]             cnt;
  logic                         done;

  modport master (output enter, del, clr, sw, input disp, stage, cnt, done);
  modport slave  (input enter, del, clr, sw, output disp, stage, cnt, done);
endinterface

// File: rtl/digit_entry_buffer_rise_detect.sv
// Rising-edge detector; the history flop keeps sampling through reset so a level
// held across reset release does not look like a fresh edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic d_r;

  always_ff @(posedge clk) begin
    d_r <= d;
  end

  assign pulse = d & ~d_r & ~rst;
endmodule

// File: rtl/digit_entry_buffer.sv
// Digit entry buffer: stages digits on enter edges and commits the full word to disp
// when the last slot is entered. Priority per cycle: rst > clr > del edge > enter edge.
module digit_entry_buffer
  import digit_entry_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  digit_entry_if.slave bus
);
  localparam int SLOT_W = slot_w(DATA_W);
  localparam int CNT_W  = cnt_w(NUM_DIGITS);
  localparam int W      = NUM_DIGITS * SLOT_W;

  localparam logic [SLOT_W-1:0] BLANK     = SLOT_W'(blank(SLOT_W));
  localparam logic [W-1:0]      ALL_BLANK = {NUM_DIGITS{BLANK}};
  localparam logic [CNT_W-1:0]  LAST      = CNT_W'(NUM_DIGITS - 1);

  logic             pos_enter;
  logic             pos_del;
  logic [W-1:0]     disp_q, disp_n;
  logic [W-1:0]     stage_q, stage_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             done_q, done_n;
  logic [SLOT_W-1:0] code;

  rise_detect u_enter (.clk(clk), .rst(rst), .d(bus.enter), .pulse(pos_enter));
  rise_detect u_del   (.clk(clk), .rst(rst), .d(bus.del),   .pulse(pos_del));

  assign code = {1'b0, bus.sw};

  always_comb begin
    disp_n  = disp_q;
    stage_n = stage_q;
    cnt_n   = cnt_q;
    done_n  = 1'b0;
    if (bus.clr) begin
      stage_n = ALL_BLANK;
      cnt_n   = '0;
    end else if (pos_del) begin
      if (cnt_q != '0) begin
        stage_n[(int'(cnt_q) - 1) * SLOT_W +: SLOT_W] = BLANK;
        cnt_n = cnt_q - 1'b1;
      end
    end else if (pos_enter) begin
      // Explicit compare so non-power-of-two slot counts wrap correctly.
      if (cnt_q == LAST) begin
        disp_n = stage_q;
        disp_n[(NUM_DIGITS - 1) * SLOT_W +: SLOT_W] = code;
        stage_n = ALL_BLANK;
        cnt_n   = '0;
        done_n  = 1'b1;
      end else begin
        stage_n[int'(cnt_q) * SLOT_W +: SLOT_W] = code;
        cnt_n = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q  <= ALL_BLANK;
      stage_q <= ALL_BLANK;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      disp_q  <= disp_n;
      stage_q <= stage_n;
      cnt_q   <= cnt_n;
      done_q  <= done_n;
    end
  end

  assign bus.disp  = disp_q;
  assign bus.stage = stage_q;
  assign bus.cnt   = cnt_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_digit_entry_buffer.sv
// Drives four parameterisations with shared stimulus and checks each against a
// list-based model of staged and committed digits.
module tb_digit_entry_buffer;
  localparam int NC = 4;
  localparam int ND [NC] = '{4, 1, 3, 8};
  localparam int DW [NC] = '{4, 3, 5, 5};

  logic       clk;
  logic       rst;
  logic       enter, del, clr;
  logic [7:0] sw;

  int compared;
  int mismatched;

  // Model: staged digit list per config, committed word, done flag.
  int stg [NC][8];
  int dsp [NC][8];
  bit dv  [NC][8];
  int n   [NC];
  bit dn  [NC];
  bit pe_prev, pd_prev;

  digit_entry_if #(.NUM_DIGITS(4), .DATA_W(4)) b0 ();
  digit_entry_if #(.NUM_DIGITS(1), .DATA_W(3)) b1 ();
  digit_entry_if #(.NUM_DIGITS(3), .DATA_W(5)) b2 ();
  digit_entry_if #(.NUM_DIGITS(8), .DATA_W(5)) b3 ();

  assign b0.enter = enter; assign b0.del = del; assign b0.clr = clr; assign b0.sw = sw[3:0];
  assign b1.enter = enter; assign b1.del = del; assign b1.clr = clr; assign b1.sw = sw[2:0];
  assign b2.enter = enter; assign b2.del = del; assign b2.clr = clr; assign b2.sw = sw[4:0];
  assign b3.enter = enter; assign b3.del = del; assign b3.clr = clr; assign b3.sw = sw[4:0];

  digit_entry_buffer #(.NUM_DIGITS(4), .DATA_W(4)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  digit_entry_buffer #(.NUM_DIGITS(1), .DATA_W(3)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  digit_entry_buffer #(.NUM_DIGITS(3), .DATA_W(5)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  digit_entry_buffer #(.NUM_DIGITS(8), .DATA_W(5)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] blank_code(int c);
    return (64'd1 << (DW[c] + 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] exp_stage(int c);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < ND[c]; i++)
      r |= ((i < n[c]) ? 64'(stg[c][i]) : blank_code(c)) << (i * (DW[c] + 1));
    return r;
  endfunction

  function automatic logic [63:0] exp_disp(int c);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < ND[c]; i++)
      r |= (dv[c][i] ? 64'(dsp[c][i]) : blank_code(c)) << (i * (DW[c] + 1));
    return r;
  endfunction

  task automatic model_edge();
    bit pe, pd;
    int v;
    pe = enter & ~pe_prev;
    pd = del & ~pd_prev;
    pe_prev = enter;
    pd_prev = del;
    for (int c = 0; c < NC; c++) begin
      v = int'(sw) & ((1 << DW[c]) - 1);
      dn[c] = 1'b0;
      if (rst) begin
        n[c] = 0;
        for (int i = 0; i < 8; i++) dv[c][i] = 1'b0;
      end else if (clr) begin
        n[c] = 0;
      end else if (pd) begin
        if (n[c] > 0) n[c]--;
      end else if (pe) begin
        if (n[c] == ND[c] - 1) begin
          for (int i = 0; i < ND[c] - 1; i++) begin
            dsp[c][i] = stg[c][i];
            dv[c][i]  = 1'b1;
          end
          dsp[c][ND[c]-1] = v;
          dv[c][ND[c]-1]  = 1'b1;
          n[c]  = 0;
          dn[c] = 1'b1;
        end else begin
          stg[c][n[c]] = v;
          n[c]++;
        end
      end
    end
  endtask

  task automatic check(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s cfg%0d observed=%h expected=%h", tag, c, obs, exp);
    end
  endtask

  task automatic check_cfg(input int c, input logic [63:0] d, input logic [63:0] s,
                           input logic [63:0] k, input logic [63:0] p);
    check("disp",  c, d, exp_disp(c));
    check("stage", c, s, exp_stage(c));
    check("cnt",   c, k, 64'(n[c]));
    check("done",  c, p, 64'(dn[c]));
  endtask

  task automatic step(input bit r, input bit e, input bit d, input bit c, input logic [7:0] s);
    rst = r; enter = e; del = d; clr = c; sw = s;
    @(posedge clk);
    model_edge();
    #1;
    check_cfg(0, 64'(b0.disp), 64'(b0.stage), 64'(b0.cnt), 64'(b0.done));
    check_cfg(1, 64'(b1.disp), 64'(b1.stage), 64'(b1.cnt), 64'(b1.done));
    check_cfg(2, 64'(b2.disp), 64'(b2.stage), 64'(b2.cnt), 64'(b2.done));
    check_cfg(3, 64'(b3.disp), 64'(b3.stage), 64'(b3.cnt), 64'(b3.done));
  endtask

  task automatic pulse_enter(input logic [7:0] s);
    step(0, 1, 0, 0, s);
    step(0, 0, 0, 0, s);
  endtask

  task automatic pulse_del();
    step(0, 0, 1, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    pe_prev = 1'b0;
    pd_prev = 1'b0;
    for (int c = 0; c < NC; c++) begin
      n[c] = 0;
      dn[c] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        stg[c][i] = 0; dsp[c][i] = 0; dv[c][i] = 1'b0;
      end
    end
    rst = 1'b1; enter = 1'b0; del = 1'b0; clr = 1'b0; sw = 8'h00;

    repeat (3) step(1, 0, 0, 0, 8'h00);

    pulse_enter(8'd1); pulse_enter(8'd2); pulse_enter(8'd3); pulse_enter(8'd4);
    pulse_enter(8'd5); pulse_enter(8'd6); pulse_del();
    pulse_enter(8'd7); pulse_enter(8'd8); pulse_enter(8'd9);
    pulse_del();

    pulse_enter(8'd1); pulse_enter(8'd2);
    step(0, 1, 1, 0, 8'd3);
    step(0, 0, 0, 0, 8'd3);

    pulse_enter(8'd2); pulse_enter(8'd3);
    step(0, 0, 0, 1, 8'd0);
    step(0, 0, 0, 0, 8'd0);

    step(1, 1, 0, 0, 8'd6);
    step(1, 1, 0, 0, 8'd6);
    repeat (3) step(0, 1, 0, 0, 8'd6);
    step(0, 0, 0, 0, 8'd6);
    pulse_enter(8'd4);
    pulse_enter(8'd5);
    step(1, 0, 0, 0, 8'd0);
    step(0, 0, 0, 0, 8'd0);

    repeat (6) pulse_enter(8'hFF);

    for (int k = 0; k < 800; k++) begin
      step(($urandom % 60) == 0,
           $urandom % 2,
           ($urandom % 5) == 0,
           ($urandom % 25) == 0,
           (($urandom % 4) == 0) ? 8'hFF : 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/digit_entry_buffer.md
# digit_entry_buffer

Parametrised keypad/switch entry buffer for the seven-segment display path. Each rising edge of `enter` captures `sw` into a staging register. When the last digit is captured, the whole staged word is committed to the display outputs in one step. It adds backspace, abort, a live staging view and a commit pulse. It sits between the debounced board inputs and the seven-segment multiplexer/decoder, which treats an all-ones slot code as blank.

## Interface
- `NUM_DIGITS`, 4: number of display slots; must be ≥ 1.
- `DATA_W`, 4: width of one entered value (`sw` width).
- `SLOT_W`, `DATA_W+1`: derived, not overridable; slot code width.
- `clk`  in  1: single clock; every register updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `enter`  in  1: debounced level; only the rising edge acts.
- `del`  in  1: debounced level; the rising edge removes the last staged digit.
- `clr`  in  1: level; while high, staging is aborted.
- `sw`  in  `DATA_W`: value captured on an `enter` edge.
- `disp`  out  `NUM_DIGITS*SLOT_W`: committed slots; slot i is at bits [i*SLOT_W +: SLOT_W].
- `stage`  out  `NUM_DIGITS*SLOT_W`: live staging slots, same layout as `disp`.
- `cnt`  out  `CNT_W`: digits currently staged, 0..NUM_DIGITS-1. `CNT_W = max(1, $clog2(NUM_DIGITS))`.
- `done`  out  1: one-cycle pulse on the cycle after a commit edge.

## Operation
- Slot codes:
  - A valid digit is `{1'b0, sw}`.
  - BLANK is all ones in `SLOT_W` bits.
  - `sw` = all ones is therefore distinct from BLANK.
- Edge detection: `enter_r` and `del_r` register the previous input level every cycle, including during reset.
  - `pos_enter = enter & ~enter_r`; `pos_del = del & ~del_r`.
  - An input held high through reset release therefore produces no edge.
- Priority per cycle is rst > clr > pos_del > pos_enter. Only one action is taken per cycle.
- rst:
  - `disp` and `stage` all BLANK.
  - `cnt` = 0, `done` = 0.
- clr high: `stage` all BLANK, `cnt` = 0; `disp` is unchanged. Edges occurring in that cycle are discarded.
- pos_del:
  - If `cnt` > 0: `stage[cnt-1]` becomes BLANK and `cnt` decrements.
  - If `cnt` = 0: no change.
  - A pos_enter in the same cycle is discarded.
- pos_enter with `cnt` < NUM_DIGITS-1: `stage[cnt]` gets the digit code and `cnt` increments. Other slots are unchanged.
- pos_enter with `cnt` = NUM_DIGITS-1 (commit):
  - `disp` gets the staged word with slot NUM_DIGITS-1 replaced by the digit code.
  - `stage` goes all BLANK and `cnt` goes to 0.
  - `done` pulses.
- NUM_DIGITS = 1: every enter edge is a commit.
- The `cnt` wrap is explicit (compare against NUM_DIGITS-1). Power-of-two overflow must not be relied on.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency from `enter` rising at edge k to the updated `stage`/`cnt` (or `disp`) is 1 cycle: the outputs are valid after edge k+1.
- `done` is high for exactly the cycle after the commit edge. It cannot be high in two consecutive cycles.
- A held `enter` or `del` acts once. Rising again requires at least one low sample.
- Reset mid-entry discards staged digits and blanks `disp` on the next edge. The first post-reset edge is honoured only after the input has been sampled low.

## Structure
- Package `digit_entry_pkg`:
  - function `slot_w(data_w)`
  - function `blank(slot_w)` returning all ones
  - function `cnt_w(num_digits)`
- Sub-module `rise_detect`:
  - ports `clk`, `rst`, `d`, `pulse`.
  - It is instantiated twice (`enter`, `del`).
  - It samples `d` even in reset, so its output is 0 during reset.
- Main block: one `always @(posedge clk)` register bank plus one combinational next-state block, with a priority if/else chain as above.

## Test plan
- Reset, then `enter` edges with `sw` = 1,2,3,4 (NUM_DIGITS = 4):
  - `cnt` reads 1,2,3, then 0.
  - `stage` fills progressively; after the 4th edge `disp` = {4,3,2,1} as codes 0x04..0x01, with slot 0 = 0x01.
  - `stage` is all 0x1F; `done` is high for 1 cycle.
- Enter 5,6, then a `del` edge: `cnt` = 1, slot 1 = 0x1F. Enter 7,8,9: `disp` slots 0..3 = 0x05,0x07,0x08,0x09.
- `del` edge at `cnt` = 0: no change anywhere. `enter` and `del` rise in the same cycle at `cnt` = 2: `cnt` = 1, no digit captured.
- `clr` pulsed at `cnt` = 3: `stage` is blank, `cnt` = 0, `disp` keeps the previous word, and `done` stays 0.
- `enter` held high across rst deassertion: no capture until `enter` falls and rises again. rst asserted at `cnt` = 2: everything is blank and 0 one cycle later.
- Parameter sweep NUM_DIGITS = 1, 3, 8 and DATA_W = 3, 5, including `sw` = all ones:
  - Commits occur at `cnt` wrap.
  - Slot code `{0, sw}` is never equal to BLANK.
